// File: rtl/math_booth_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
// Used by the encoder and the top-level sequencer.
package math_booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } booth_seq_state_t;

  localparam int BOOTH_R4_GROUP_W = 3;

endpackage

// File: rtl/math_multiplier_booth_radix_4_encoder.sv
// Radix-4 Booth encoder: maps a 3-bit group to 0, +-M or +-2M.
// Operands are W bits wide; the partial product is W+1 bits wide.
module math_multiplier_booth_radix_4_encoder
  import math_booth_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0]                m_i,
  input  logic [W-1:0]                mneg_i,
  input  logic [BOOTH_R4_GROUP_W-1:0] grp_i,
  output logic [W:0]                  pp_o
);

  logic pos1;
  logic pos2;
  logic neg1;
  logic neg2;

  assign pos1 = (grp_i == 3'b001) || (grp_i == 3'b010);
  assign pos2 = (grp_i == 3'b011);
  assign neg2 = (grp_i == 3'b100);
  assign neg1 = (grp_i == 3'b101) || (grp_i == 3'b110);

  always_comb begin
    pp_o = '0;
    unique case (1'b1)
      pos1:    pp_o = {m_i[W-1], m_i};
      pos2:    pp_o = {m_i, 1'b0};
      neg2:    pp_o = {mneg_i, 1'b0};
      neg1:    pp_o = {mneg_i[W-1], mneg_i};
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/math_multiplier_booth_radix_4_seq.sv
// Iterative signed NxN radix-4 Booth multiplier, one group per clock.
// Define MATH_BOOTH_R4_EARLY_TERM_EN to stop once remaining groups encode 0.
module math_multiplier_booth_radix_4_seq
  import math_booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [N-1:0]   i_multiplicand,
  input  logic [N-1:0]   i_multiplier,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [2*N-1:0] o_product,
  output logic           o_busy
);

  localparam int W  = N + 1;
  localparam int KW = $clog2(N / 2) + 1;
  localparam logic [KW-1:0] KLAST = KW'(N / 2 - 1);

  booth_seq_state_t state_q, state_d;

  logic [W-1:0]   m_q, m_d;
  logic [W-1:0]   mneg_q, mneg_d;
  logic [W-1:0]   qsr_q, qsr_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [KW-1:0]  k_q, k_d;

  logic [W-1:0]   m_ext;
  logic [W-1:0]   qsr_sh;
  logic [W:0]     pp;
  logic [2*N-1:0] pp_ext;
  logic           last;

  assign m_ext  = {i_multiplicand[N-1], i_multiplicand};
  assign qsr_sh = {{2{qsr_q[W-1]}}, qsr_q[W-1:2]};
  assign pp_ext = {{(N-2){pp[W]}}, pp};

  math_multiplier_booth_radix_4_encoder #(
    .W (W)
  ) u_enc (
    .m_i    (m_q),
    .mneg_i (mneg_q),
    .grp_i  (qsr_q[BOOTH_R4_GROUP_W-1:0]),
    .pp_o   (pp)
  );

`ifdef MATH_BOOTH_R4_EARLY_TERM_EN
  // Shifted register holds Q[N-1:2k+1] sign-filled; uniform means all zero groups.
  logic rem_eq;
  assign rem_eq = (qsr_sh == '0) || (qsr_sh == '1);
  assign last   = (k_q == KLAST) || rem_eq;
`else
  assign last   = (k_q == KLAST);
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    mneg_d  = mneg_q;
    qsr_d   = qsr_q;
    acc_d   = acc_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          m_d     = m_ext;
          mneg_d  = -m_ext;
          qsr_d   = {i_multiplier, 1'b0};
          acc_d   = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + (pp_ext << {k_q, 1'b0});
        qsr_d = qsr_sh;
        k_d   = k_q + 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      mneg_q  <= '0;
      qsr_q   <= '0;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      mneg_q  <= mneg_d;
      qsr_q   <= qsr_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
    end
  end

  assign o_ready   = (state_q == IDLE) && !i_rst;
  assign o_valid   = (state_q == DONE);
  assign o_busy    = (state_q != IDLE);
  assign o_product = acc_q;

endmodule
